// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, IDCODE/BYPASS DRs and user DR channels.
// Build option JTAG_TAP_LOCK_EN enables the lock_i instruction filter (IDCODE/BYPASS only).
//
// state    | meaning
// TLR      | test-logic-reset, ir forced to IDCODE
// RTI      | run-test/idle
// SEL_DR   | select DR scan
// CAP_DR   | capture DR (IDCODE value / bypass 0)
// SH_DR    | shift DR, tdo from selected DR
// EX1_DR   | exit1 DR
// PAUSE_DR | pause DR
// EX2_DR   | exit2 DR
// UPD_DR   | update DR
// SEL_IR   | select IR scan
// CAP_IR   | capture IR (01 pattern)
// SH_IR    | shift IR
// EX1_IR   | exit1 IR
// PAUSE_IR | pause IR
// EX2_IR   | exit2 IR
// UPD_IR   | update IR, load active instruction
module jtag_tap_ctrl #(
  parameter int unsigned         IR_WIDTH   = 5,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter int unsigned         NUM_USER   = 2,
  parameter logic [IR_WIDTH-1:0] USER_BASE  = IR_WIDTH'(5'h10)
) (
  input  logic                tck_i,
  input  logic                rst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                lock_i,
  input  logic [NUM_USER-1:0] user_tdo_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic                test_logic_reset_o,
  output logic [3:0]          state_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic [NUM_USER-1:0] user_sel_o,
  output logic                capture_dr_o,
  output logic                shift_dr_o,
  output logic                update_dr_o
);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);

  tap_state_e          state_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         idcode_sr;
  logic                bypass_q;
  logic [NUM_USER-1:0] user_sel;
  logic                sel_idcode;
  logic                sel_user;
  logic                user_tdo;
  logic                lock_act;
  logic [IR_WIDTH-1:0] upd_op;

`ifdef JTAG_TAP_LOCK_EN
  assign lock_act = lock_i;
`else
  logic unused_lock;
  assign unused_lock = lock_i;
  assign lock_act    = 1'b0;
`endif

  always_comb begin
    user_sel = '0;
    user_tdo = 1'b0;
    for (int k = 0; k < int'(NUM_USER); k++) begin
      user_sel[k] = (ir_q == USER_BASE + IR_WIDTH'(k));
      if (user_sel[k]) user_tdo = user_tdo_i[k];
    end
  end

  assign sel_idcode = (ir_q == OP_IDCODE);
  assign sel_user   = |user_sel;
  // While locked only IDCODE and BYPASS may become active.
  assign upd_op     = (lock_act && ir_sr != OP_IDCODE && ir_sr != OP_BYPASS) ? OP_BYPASS : ir_sr;

  always_ff @(posedge tck_i) begin
    if (!rst_ni) begin
      state_q   <= TLR;
      ir_q      <= OP_IDCODE;
      ir_sr     <= '0;
      idcode_sr <= IDCODE_VAL;
      bypass_q  <= 1'b0;
      tdo_o     <= 1'b0;
      tdo_oe_o  <= 1'b0;
    end else begin
      unique case (state_q)
        TLR:      state_q <= tms_i ? TLR    : RTI;
        RTI:      state_q <= tms_i ? SEL_DR : RTI;
        SEL_DR:   state_q <= tms_i ? SEL_IR : CAP_DR;
        CAP_DR:   state_q <= tms_i ? EX1_DR : SH_DR;
        SH_DR:    state_q <= tms_i ? EX1_DR : SH_DR;
        EX1_DR:   state_q <= tms_i ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_q <= tms_i ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_q <= tms_i ? UPD_DR : SH_DR;
        UPD_DR:   state_q <= tms_i ? SEL_DR : RTI;
        SEL_IR:   state_q <= tms_i ? TLR    : CAP_IR;
        CAP_IR:   state_q <= tms_i ? EX1_IR : SH_IR;
        SH_IR:    state_q <= tms_i ? EX1_IR : SH_IR;
        EX1_IR:   state_q <= tms_i ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_q <= tms_i ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_q <= tms_i ? UPD_IR : SH_IR;
        UPD_IR:   state_q <= tms_i ? SEL_DR : RTI;
        default:  state_q <= TLR;
      endcase

      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
      case (state_q)
        CAP_IR: ir_sr <= IR_WIDTH'(2'b01);
        SH_IR: begin
          tdo_o    <= ir_sr[0];
          tdo_oe_o <= 1'b1;
          ir_sr    <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
        end
        CAP_DR: begin
          idcode_sr <= IDCODE_VAL;
          bypass_q  <= 1'b0;
        end
        SH_DR: begin
          tdo_oe_o <= 1'b1;
          if (sel_idcode) begin
            tdo_o     <= idcode_sr[0];
            idcode_sr <= {tdi_i, idcode_sr[31:1]};
          end else if (sel_user) begin
            tdo_o <= user_tdo;
          end else begin
            tdo_o    <= bypass_q;
            bypass_q <= tdi_i;
          end
        end
        default: ;
      endcase

      if (state_q == TLR)              ir_q <= OP_IDCODE;
      else if (state_q == UPD_IR)      ir_q <= upd_op;
      else if (lock_act && sel_user)   ir_q <= OP_BYPASS;
    end
  end

  assign state_o            = state_q;
  assign test_logic_reset_o = (state_q == TLR);
  assign capture_dr_o       = (state_q == CAP_DR);
  assign shift_dr_o         = (state_q == SH_DR);
  assign update_dr_o        = (state_q == UPD_DR);
  assign ir_o               = ir_q;
  assign user_sel_o         = user_sel;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized scoreboard bench for jtag_tap_ctrl against a queue-based TAP reference model.
module tb_jtag_tap_ctrl;
  localparam int          IRW   = 5;
  localparam int          NU    = 2;
  localparam int          UBASE = 16;
  localparam logic [31:0] IDC   = 32'h1000_0001;
`ifdef JTAG_TAP_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SDR = 4'h7, CDR = 4'h6, SHDR = 4'h2,
                         E1DR = 4'h1, PDR = 4'h3, E2DR = 4'h0, UDR = 4'h5, SIR = 4'h4,
                         CIR = 4'hE, SHIR = 4'hA, E1IR = 4'h9, PIR = 4'hB, E2IR = 4'h8,
                         UIR = 4'hD;

  logic           tck_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           tms_i = 1'b0;
  logic           tdi_i = 1'b0;
  logic           lock_i = 1'b0;
  logic [NU-1:0]  user_tdo_i = '0;
  logic           tdo_o, tdo_oe_o, test_logic_reset_o;
  logic [3:0]     state_o;
  logic [IRW-1:0] ir_o;
  logic [NU-1:0]  user_sel_o;
  logic           capture_dr_o, shift_dr_o, update_dr_o;

  jtag_tap_ctrl dut (
    .tck_i(tck_i), .rst_ni(rst_ni), .tms_i(tms_i), .tdi_i(tdi_i), .lock_i(lock_i),
    .user_tdo_i(user_tdo_i), .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
    .test_logic_reset_o(test_logic_reset_o), .state_o(state_o), .ir_o(ir_o),
    .user_sel_o(user_sel_o), .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o),
    .update_dr_o(update_dr_o)
  );

  always #5 tck_i = ~tck_i;

  typedef struct {
    logic [3:0]     st;
    logic [IRW-1:0] ir;
    logic           tdo;
    logic           oe;
    logic           tlr;
    logic [NU-1:0]  usel;
    logic           cap;
    logic           sh;
    logic           upd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hist = '0;
  bit          rst_v = 1'b0;
  bit          lock_v = 1'b0;

  // Reference model: serial register contents kept as a bit queue, front = next bit out.
  logic [3:0]     nxt0[16];
  logic [3:0]     nxt1[16];
  logic [3:0]     m_state = TLR;
  logic [IRW-1:0] m_ir = IRW'(1);
  bit             m_tdo = 1'b0;
  bit             m_oe = 1'b0;
  bit             m_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_tr(logic [3:0] s, logic [3:0] on0, logic [3:0] on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  function automatic int user_idx(logic [IRW-1:0] op);
    int v;
    v = int'(op);
    if (v >= UBASE && v < UBASE + NU) return v - UBASE;
    return -1;
  endfunction

  task automatic model_step(bit rst_n, bit tms, bit tdi, bit lock, logic [NU-1:0] ut);
    logic [3:0]     cur;
    logic [IRW-1:0] op;
    logic [31:0]    idv;
    int             ui;
    if (!rst_n) begin
      m_state = TLR;
      m_ir    = IRW'(1);
      m_tdo   = 1'b0;
      m_oe    = 1'b0;
      m_q.delete();
      return;
    end
    cur   = m_state;
    ui    = user_idx(m_ir);
    m_tdo = 1'b0;
    m_oe  = 1'b0;
    if (cur == SHIR || cur == SHDR) begin
      m_oe = 1'b1;
      if (cur == SHDR && ui >= 0) m_tdo = ut[ui];
      else if (m_q.size() > 0) begin
        m_tdo = m_q.pop_front();
        m_q.push_back(tdi);
      end
    end
    if (cur == CIR) begin
      m_q.delete();
      for (int i = 0; i < IRW; i++) m_q.push_back(i == 0);
    end
    if (cur == CDR) begin
      m_q.delete();
      idv = IDC;
      if (m_ir == IRW'(1)) for (int i = 0; i < 32; i++) m_q.push_back(idv[i]);
      else m_q.push_back(1'b0);
    end
    if (cur == TLR) m_ir = IRW'(1);
    else if (cur == UIR) begin
      op = '0;
      for (int i = 0; i < IRW && i < m_q.size(); i++) op[i] = m_q[i];
      if (LOCK_EN && lock && op != IRW'(1) && op != '1) op = '1;
      m_ir = op;
    end else if (LOCK_EN && lock && ui >= 0) m_ir = '1;
    m_state = tms ? nxt1[cur] : nxt0[cur];
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    int   ui;
    ui     = user_idx(m_ir);
    e.st   = m_state;
    e.ir   = m_ir;
    e.tdo  = m_tdo;
    e.oe   = m_oe;
    e.tlr  = (m_state == TLR);
    e.usel = (ui >= 0) ? (NU'(1) << ui) : '0;
    e.cap  = (m_state == CDR);
    e.sh   = (m_state == SHDR);
    e.upd  = (m_state == UDR);
    return e;
  endfunction

  task automatic tick(bit tms, bit tdi);
    logic [NU-1:0] ut;
    @(negedge tck_i);
    ut         = NU'($urandom);
    rst_ni     = rst_v;
    tms_i      = tms;
    tdi_i      = tdi;
    lock_i     = lock_v;
    user_tdo_i = ut;
    model_step(rst_v, tms, tdi, lock_v, ut);
    exp_q.push_back(make_exp());
  endtask

  task automatic after_edge();
    @(posedge tck_i);
    #2;
  endtask

  // Starts and ends in Run-Test/Idle.
  task automatic load_ir(logic [IRW-1:0] op);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) tick(i == IRW - 1, op[i]);
    tick(1, 0); tick(0, 0);
  endtask

  always @(posedge tck_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state_o", 32'(state_o), 32'(e.st));
      chk("ir_o", 32'(ir_o), 32'(e.ir));
      chk("tdo_o", 32'(tdo_o), 32'(e.tdo));
      chk("tdo_oe_o", 32'(tdo_oe_o), 32'(e.oe));
      chk("test_logic_reset_o", 32'(test_logic_reset_o), 32'(e.tlr));
      chk("user_sel_o", 32'(user_sel_o), 32'(e.usel));
      chk("capture_dr_o", 32'(capture_dr_o), 32'(e.cap));
      chk("shift_dr_o", 32'(shift_dr_o), 32'(e.sh));
      chk("update_dr_o", 32'(update_dr_o), 32'(e.upd));
      if (tdo_oe_o === 1'b1) hist = {tdo_o, hist[31:1]};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]     pat;
    logic [IRW-1:0] op;
    int             w;
    set_tr(TLR, RTI, TLR);   set_tr(RTI, RTI, SDR);
    set_tr(SDR, CDR, SIR);   set_tr(SIR, CIR, TLR);
    set_tr(CDR, SHDR, E1DR); set_tr(SHDR, SHDR, E1DR);
    set_tr(E1DR, PDR, UDR);  set_tr(PDR, PDR, E2DR);
    set_tr(E2DR, SHDR, UDR); set_tr(UDR, RTI, SDR);
    set_tr(CIR, SHIR, E1IR); set_tr(SHIR, SHIR, E1IR);
    set_tr(E1IR, PIR, UIR);  set_tr(PIR, PIR, E2IR);
    set_tr(E2IR, SHIR, UIR); set_tr(UIR, RTI, SDR);

    rst_v = 1'b0; tick(0, 0);
    rst_v = 1'b1;

    // IDCODE shift out of Shift-DR
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 32; i++) tick(i == 31, 1'($urandom_range(0, 1)));
    after_edge();
    chk("idcode_stream", hist, IDC);
    tick(0, 0);
    repeat (5) tick(1, 0);

    // IR capture pattern
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) tick(i == IRW - 1, 1'b1);
    after_edge();
    chk("ir_capture_stream", hist >> (32 - IRW), 32'h1);
    tick(1, 0); tick(0, 0);

    // BYPASS: A5 comes back one bit late behind a leading 0
    pat = 8'hA5;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 9; i++) tick(i == 8, (i < 8) ? pat[i] : 1'b0);
    after_edge();
    chk("bypass_stream", hist >> 23, {23'h0, 8'hA5, 1'b0});
    tick(1, 0); tick(0, 0);

    // Lock while loading a user opcode
    lock_v = 1'b1;
    load_ir(IRW'(5'h10));
    after_edge();
    chk("locked_load_ir", 32'(ir_o), LOCK_EN ? 32'h1F : 32'h10);
    chk("locked_load_sel", 32'(user_sel_o), LOCK_EN ? 32'h0 : 32'h1);

    // Lock rising with a user opcode active
    lock_v = 1'b0;
    tick(0, 0);
    load_ir(IRW'(5'h11));
    lock_v = 1'b1;
    tick(0, 0);
    after_edge();
    chk("lock_rise_ir", 32'(ir_o), LOCK_EN ? 32'h1F : 32'h11);
    chk("lock_rise_tlr", 32'(test_logic_reset_o), 32'h0);
    lock_v = 1'b0;

    // Reset in the middle of an IR shift
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 1);
    rst_v = 1'b0; tick(0, 0); rst_v = 1'b1;
    after_edge();
    chk("midshift_reset_ir", 32'(ir_o), 32'h1);
    chk("midshift_reset_state", 32'(state_o), 32'hF);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) lock_v = ~lock_v;
      if ($urandom_range(0, 14) == 0) begin
        rst_v = 1'b1;
        case ($urandom_range(0, 4))
          0:       op = IRW'(UBASE);
          1:       op = IRW'(UBASE + 1);
          2:       op = IRW'(1);
          3:       op = '1;
          default: op = IRW'($urandom);
        endcase
        repeat (5) tick(1, 0);
        tick(0, 0);
        load_ir(op);
      end else begin
        rst_v = ($urandom_range(0, 299) != 0);
        tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      end
    end

    rst_v = 1'b1;
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      after_edge();
      w++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

Parametrised IEEE 1149.1 TAP controller for the debug subsystem: full 16-state TAP FSM, instruction register of configurable width, IDCODE and BYPASS data registers, and NUM_USER user data-register channels routed to external debug modules. `test_logic_reset_o` is derived only from the FSM state, so no side input can assert or mask it. An optional lock input restricts the decoded instruction set to IDCODE/BYPASS while asserted.

## Interface
- IR_WIDTH, 5: instruction register width, minimum 2.
- IDCODE_VAL, 32'h1000_0001: IDCODE register capture value; bit 0 must be 1.
- NUM_USER, 2: number of user DR channels, 1..8.
- USER_BASE, 5'h10: opcode of user channel 0; channel k uses USER_BASE+k.

Ports:
- tck_i  in  1  TAP clock; the only clock.
- rst_ni  in  1  reset; synchronous, active-low.
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in.
- lock_i  in  1  debug lock; 1 = only IDCODE/BYPASS permitted.
- user_tdo_i  in  NUM_USER  serial return from each user DR.
- tdo_o  out  1  test data out, registered.
- tdo_oe_o  out  1  1 while tdo_o carries shifted data.
- test_logic_reset_o  out  1  1 exactly when the FSM is in Test-Logic-Reset.
- state_o  out  4  current FSM state encoding.
- ir_o  out  IR_WIDTH  active (updated) instruction.
- user_sel_o  out  NUM_USER  one-hot select of the active user instruction.
- capture_dr_o / shift_dr_o / update_dr_o  out  1 each  FSM in Capture-DR / Shift-DR / Update-DR; qualified by user_sel_o downstream.

## Operation
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions (tms=0 / tms=1): TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; SelIR→CapIR/TLR; Cap→Sh/Ex1; Sh→Sh/Ex1; Ex1→Pause/Upd; Pause→Pause/Ex2; Ex2→Sh/Upd; Upd→RTI/SelDR. IR and DR branches are symmetric.
- Instructions: all-ones = BYPASS; 1 = IDCODE; USER_BASE+k = user channel k; any other opcode behaves as BYPASS.
- IR: shift register ir_sr plus active register ir_o. CapIR loads ir_sr = {0…0,2'b01}. ShIR: ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]}. UpdIR: ir_o <= filtered ir_sr.
- DR: BYPASS is 1 bit, captures 0. IDCODE is 32 bits, captures IDCODE_VAL. Both shift LSB-first with tdi_i into the MSB. User DRs are external; only user_tdo_i[k] is muxed.
- tdo_o: in ShIR, tdo_o <= ir_sr[0]; in ShDR, tdo_o <= LSB of selected DR (or user_tdo_i[k]); tdo_oe_o <= 1 in ShIR/ShDR, else 0 and tdo_o <= 0.
- Lock filter: while lock_i=1, UpdIR loads BYPASS for any opcode other than IDCODE/BYPASS. If lock_i=1 while ir_o is a user opcode, ir_o <= BYPASS on the next edge; user_sel_o drops in the same edge.
- Every cycle in TLR: ir_o <= IDCODE. test_logic_reset_o = (state == TLR), no other term.

## Timing
- Reset (rst_ni=0 at posedge): state=TLR, ir_o=IDCODE, ir_sr=0, bypass=0, tdo_o=0, tdo_oe_o=0, user_sel_o=0; test_logic_reset_o=1 from that edge.
- State and all outputs update on posedge tck_i; state_o and strobes are 0-cycle decodes of the state register.
- tdo_o: 1-cycle latency after the shift edge. BYPASS path is tdi→tdo delay of 2 edges.
- Five consecutive tms_i=1 edges reach TLR from any state.
- Reset asserted mid-shift aborts; no Update occurs, and ir_o returns to IDCODE.
- Simultaneous UpdIR with lock_i rising: the filter applies to the loaded value.

## Configuration
- JTAG_TAP_LOCK_EN defined: lock_i filter and forced-BYPASS behaviour active.
- Not defined: lock_i ignored (port retained, unconnected internally); all opcodes decode normally.

## Test plan
- rst_ni=0 one edge, then TMS 0,1,0,0 (ShDR), shift 32 bits → tdo stream 32'h1000_0001 LSB-first; test_logic_reset_o=1 only while in TLR.
- From PauseDR drive tms=1 ×5 → state_o=F after 5th edge, ir_o=IDCODE.
- Enter ShIR with IR_WIDTH=5 → first 5 tdo bits 1,0,0,0,0 (capture 01 pattern).
- Load BYPASS (5'h1F), shift 8'hA5 in ShDR → tdo reproduces A5 delayed by one bit, first bit 0.
- lock_i=1, load opcode 5'h10 → ir_o=5'h1F, user_sel_o=0; with JTAG_TAP_LOCK_EN undefined → ir_o=5'h10, user_sel_o=2'b01.
- ir_o=5'h11 active, raise lock_i in RTI → next edge ir_o=5'h1F, user_sel_o=0; test_logic_reset_o stays 0.
